// File: rtl/div_ctrl_if.sv
// Control/status bundle of the clock divider: run control, ratio handshake,
// divided clock and phase observation.
interface div_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic         stop;
  logic         cfg_valid;
  logic [W-1:0] cfg_ratio;
  logic         cfg_ready;
  logic         cfg_err;
  logic         f;
  logic         tick;
  logic         busy;
  logic [W-1:0] cnt;

  modport master (
    output start, stop, cfg_valid, cfg_ratio,
    input  cfg_ready, cfg_err, f, tick, busy, cnt
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_ratio,
    output cfg_ready, cfg_err, f, tick, busy, cnt
  );
endinterface

// File: rtl/div_ctrl.sv
// Programmable 50%-duty clock divider (N = 2..2^W-1) with a glitch-free ratio
// update that only lands on an output period boundary or while idle.
module div_ctrl #(
  parameter int DEFAULT_RATIO = 5,
  parameter int W             = 4
) (
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [W-1:0] RESET_RATIO = W'(DEFAULT_RATIO);
  localparam logic [W-1:0] MIN_RATIO   = W'(2);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ratio_q, ratio_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         p_q, p_d;
  logic         n_q;
  logic         err_q, err_d;

  logic         running;
  logic         at_last;
  logic         cfg_illegal;
  logic         cfg_accept;
  logic         apply_pend;

  assign running     = (state_q != IDLE);
  assign at_last     = (cnt_q == (ratio_q - W'(1)));
  assign cfg_illegal = (bus.cfg_ratio < MIN_RATIO);
  assign cfg_accept  = bus.cfg_valid && !pend_vld_q && !cfg_illegal;

  // A pending ratio may only land where no f period can be cut or stretched:
  // any cycle in IDLE, or the RUN wrap. DRAIN finishes on the old ratio.
  assign apply_pend  = pend_vld_q && ((state_q == IDLE) || ((state_q == RUN) && at_last));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && !bus.stop) state_d = RUN;
      RUN:     if (bus.stop)               state_d = DRAIN;
      DRAIN:   if (at_last)                state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    ratio_d    = ratio_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (apply_pend) begin
      ratio_d    = pend_q;
      pend_vld_d = 1'b0;
    end
    if (cfg_accept) begin
      pend_d     = bus.cfg_ratio;
      pend_vld_d = 1'b1;
    end

    if ((state_d == IDLE) || (state_q == IDLE) || at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end

    // p is the registered "first half" flag; using ratio_d keeps it right on the update edge.
    p_d   = (state_d != IDLE) && (cnt_d < (ratio_d >> 1));
    err_d = bus.cfg_valid && cfg_illegal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ratio_q    <= RESET_RATIO;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      p_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      p_q        <= p_d;
      err_q      <= err_d;
    end
  end

  // Half-cycle extension for odd ratios: p delayed to the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  assign bus.f         = ratio_q[0] ? (p_q | n_q) : p_q;
  assign bus.tick      = running && (cnt_q == '0);
  assign bus.busy      = running;
  assign bus.cfg_ready = !pend_vld_q;
  assign bus.cfg_err   = err_q;
  assign bus.cnt       = cnt_q;

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst) cnt_q < ratio_q);
  a_ratio_legal:  assert property (@(posedge clk) disable iff (!rst) ratio_q >= MIN_RATIO);
  a_idle_quiet:   assert property (@(posedge clk) disable iff (!rst)
                                   !running |-> ((cnt_q == '0) && !p_q));

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: per-cycle expectations go through a
// scoreboard queue; f is checked in both half-cycles of every clk period.
module tb_div_ctrl;

  localparam int W   = 4;
  localparam int DEF = 5;

  logic clk = 1'b0;
  logic rst;

  div_ctrl_if #(.W(W)) bus ();

  div_ctrl #(.DEFAULT_RATIO(DEF), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit tick;
    bit busy;
    bit f0;
    bit f1;
    bit rdy;
    bit err;
  } exp_t;

  typedef struct {
    logic [W-1:0] ratio;
    bit           exp_err;
    int           exp_n;
    int           stop_cyc;
  } cfg_vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected cycle while counting with ratio n: f is high for the first n half-cycles.
  task automatic push_run(input int c, input int n, input bit rdy, input bit err);
    exp_t e;
    e.cnt  = c;
    e.tick = (c == 0);
    e.busy = 1'b1;
    e.f0   = ((2 * c) < n);
    e.f1   = ((2 * c + 1) < n);
    e.rdy  = rdy;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic push_idle(input bit rdy, input bit err);
    exp_t e;
    e.cnt  = 0;
    e.tick = 1'b0;
    e.busy = 1'b0;
    e.f0   = 1'b0;
    e.f1   = 1'b0;
    e.rdy  = rdy;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Waits one clk, samples after the rising and after the falling edge, compares.
  task automatic sample(input string tag, input int idx);
    logic [W-1:0] a_cnt;
    logic         a_tick, a_busy, a_f0, a_f1, a_rdy, a_err;
    exp_t         e;
    @(posedge clk);
    #2;
    a_cnt  = bus.cnt;
    a_tick = bus.tick;
    a_busy = bus.busy;
    a_f0   = bus.f;
    a_rdy  = bus.cfg_ready;
    a_err  = bus.cfg_err;
    @(negedge clk);
    #2;
    a_f1 = bus.f;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s[%0d] scoreboard: got no expected entry", tag, idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s[%0d] cnt", tag, idx), a_cnt, e.cnt);
      check($sformatf("%s[%0d] tick", tag, idx), a_tick, e.tick);
      check($sformatf("%s[%0d] busy", tag, idx), a_busy, e.busy);
      check($sformatf("%s[%0d] f_rise_half", tag, idx), a_f0, e.f0);
      check($sformatf("%s[%0d] f_fall_half", tag, idx), a_f1, e.f1);
      check($sformatf("%s[%0d] cfg_ready", tag, idx), a_rdy, e.rdy);
      check($sformatf("%s[%0d] cfg_err", tag, idx), a_err, e.err);
    end
  endtask

  // Start from IDLE, hold stop during cycle stop_cyc, expect the drain to the
  // end of that period and two quiet IDLE cycles afterwards.
  task automatic run_seq(input int n, input int stop_cyc, input string tag);
    int last_busy;
    last_busy = stop_cyc + 1;
    while ((last_busy % n) != (n - 1)) last_busy++;
    bus.start = 1'b1;
    for (int i = 0; i <= last_busy + 2; i++) begin
      if (i <= last_busy) push_run(i % n, n, 1'b1, 1'b0);
      else                push_idle(1'b1, 1'b0);
      sample(tag, i);
      bus.start = 1'b0;
      bus.stop  = (i == stop_cyc);
    end
    bus.stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_vec_t vecs[5];
    vecs[0] = '{4'd1,  1'b1, 3,  3};
    vecs[1] = '{4'd2,  1'b0, 2,  2};
    vecs[2] = '{4'd0,  1'b1, 2,  4};
    vecs[3] = '{4'd7,  1'b0, 7,  1};
    vecs[4] = '{4'd15, 1'b0, 15, 15};

    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ratio = '0;
    rst           = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("reset cnt", bus.cnt, 0);
    check("reset f", bus.f, 0);
    check("reset tick", bus.tick, 0);
    check("reset busy", bus.busy, 0);
    check("reset cfg_err", bus.cfg_err, 0);
    check("reset cfg_ready", bus.cfg_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    // start together with stop is not a start
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    push_idle(1'b1, 1'b0);
    sample("start_and_stop", 0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    push_idle(1'b1, 1'b0);
    sample("start_and_stop", 1);

    run_seq(DEF, 5, "default_n5");

    // N=6 offered at cnt=2: N=5 period finishes, tick 3 clk later, then 3/3
    bus.start = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      if (i < 5)       push_run(i, 5, (i < 3), 1'b0);
      else if (i <= 10) push_run(i - 5, 6, 1'b1, 1'b0);
      else             push_idle(1'b1, 1'b0);
      sample("cfg_in_run", i);
      bus.start     = 1'b0;
      bus.cfg_valid = (i == 2);
      bus.cfg_ratio = 4'd6;
      bus.stop      = (i == 5);
    end
    bus.cfg_valid = 1'b0;
    bus.stop      = 1'b0;

    // illegal ratio while running: one-cycle cfg_err, period unchanged
    bus.start = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      if (i <= 11) push_run(i % 6, 6, 1'b1, (i == 2));
      else         push_idle(1'b1, 1'b0);
      sample("illegal_in_run", i);
      bus.start     = 1'b0;
      bus.cfg_valid = (i == 1);
      bus.cfg_ratio = 4'd1;
      bus.stop      = (i == 6);
    end
    bus.cfg_valid = 1'b0;
    bus.stop      = 1'b0;

    // stop while an update is pending: old N completes, new N lands in IDLE
    bus.start = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      if (i <= 5) push_run(i, 6, (i < 2), 1'b0);
      else        push_idle((i == 7), 1'b0);
      sample("stop_pending", i);
      bus.start     = 1'b0;
      bus.cfg_valid = (i == 1);
      bus.cfg_ratio = 4'd3;
      bus.stop      = (i == 2);
    end
    bus.cfg_valid = 1'b0;
    bus.stop      = 1'b0;
    run_seq(3, 3, "n3_after_drain");

    // ratio offers in IDLE, then the resulting waveform
    for (int v = 0; v < 5; v++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_ratio = vecs[v].ratio;
      push_idle(vecs[v].exp_err, vecs[v].exp_err);
      sample($sformatf("vec%0d_offer", v), 0);
      bus.cfg_valid = 1'b0;
      push_idle(1'b1, 1'b0);
      sample($sformatf("vec%0d_apply", v), 1);
      run_seq(vecs[v].exp_n, vecs[v].stop_cyc, $sformatf("vec%0d_run", v));
    end

    // reset mid high phase (N=15, cnt=3) with a pending ratio
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_run(i, 15, (i < 2), 1'b0);
      sample("pre_rst", i);
      bus.start     = 1'b0;
      bus.cfg_valid = (i == 1);
      bus.cfg_ratio = 4'd9;
    end
    bus.cfg_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_async f", bus.f, 0);
    check("rst_async cnt", bus.cnt, 0);
    check("rst_async busy", bus.busy, 0);
    check("rst_async tick", bus.tick, 0);
    check("rst_async cfg_ready", bus.cfg_ready, 1);
    check("rst_async cfg_err", bus.cfg_err, 0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_held cnt", bus.cnt, 0);
    check("rst_held f", bus.f, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    push_idle(1'b1, 1'b0);
    sample("post_rst", 0);
    run_seq(DEF, 5, "default_restored");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
